// File: rtl/gbif_pkg.sv
// Shared definitions for the global-buffer pad interface requester.
// IFCODEs, default transfer sizes, FSM encoding and direction helper.
package gbif_pkg;

  localparam logic [3:0] IFCODE_CFG     = 4'd0;
  localparam logic [3:0] IFCODE_FLGOFM  = 4'd1;
  localparam logic [3:0] IFCODE_OFM     = 4'd2;
  localparam logic [3:0] IFCODE_WEIADDR = 4'd3;
  localparam logic [3:0] IFCODE_WEI     = 4'd4;
  localparam logic [3:0] IFCODE_FLGWEI  = 4'd5;
  localparam logic [3:0] IFCODE_ACT     = 4'd6;
  localparam logic [3:0] IFCODE_FLGACT  = 4'd7;
  localparam logic [3:0] IFCODE_EMPTY   = 4'd15;

  localparam int SIZE_CFG     = 64;
  localparam int SIZE_WEIADDR = 54;
  localparam int SIZE_WEI     = 512;
  localparam int SIZE_FLGWEI  = 512;
  localparam int SIZE_ACT     = 512;
  localparam int SIZE_FLGACT  = 512;
  localparam int SIZE_FLGOFM  = 64;
  localparam int SIZE_OFM     = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_TURN,
    ST_WAIT_CS,
    ST_XFER,
    ST_DONE
  } state_t;

  function automatic logic is_read(input logic [3:0] ifcode);
    return !(ifcode == IFCODE_FLGOFM || ifcode == IFCODE_OFM);
  endfunction

endpackage

// File: rtl/gbif_xfer_cnt.sv
// Beat counter and WAIT_CS timeout counter for the pad requester.
// Flags are pure functions of the counts so the FSM can qualify them.
module gbif_xfer_cnt #(
  parameter int LEN_W   = 20,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             beat,
  input  logic             tick,
  input  logic [LEN_W-1:0] len,
  output logic             last,
  output logic             expire
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [LEN_W-1:0] cnt;
  logic [TMO_W-1:0] tmo;

  assign last   = (cnt == len - 1'b1);
  assign expire = (TIMEOUT != 0) && (tmo == TMO_LAST);

  // Compare happens before the increment, so cnt never exceeds len-1.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      tmo <= '0;
    end else begin
      if (beat && !last) cnt <= cnt + 1'b1;
      if (tick) tmo <= tmo + 1'b1;
    end
  end

endmodule

// File: rtl/gbif_chip_requester.sv
// Chip-side requester on the 128-bit global-buffer pad interface.
// Sends an IFCODE request, then reads host words or drives write words.
module gbif_chip_requester
  import gbif_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int LEN_W    = 20,
  parameter int CFG_HOLD = 3,
  parameter int TIMEOUT  = 1023
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_req_val,
  output logic              O_req_rdy,
  input  logic [3:0]        I_req_ifcode,
  input  logic [LEN_W-1:0]  I_req_len,
  output logic              O_config_req,
  output logic              O_switch_rdwr,
  input  logic              I_spi_cs_n,
  input  logic              I_OE_req,
  input  logic [DATA_W-1:0] I_pad_data,
  output logic [DATA_W-1:0] O_pad_data,
  output logic              O_pad_oe,
  output logic [DATA_W-1:0] O_rd_data,
  output logic              O_rd_val,
  input  logic [DATA_W-1:0] I_wr_data,
  input  logic              I_wr_val,
  output logic              O_wr_rdy,
  output logic              O_busy,
  output logic              O_done,
  output logic              O_err
);

  localparam int HOLD_W = $clog2(CFG_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CFG_HOLD - 1);

  state_t            state;
  state_t            nxt;
  logic [LEN_W-1:0]  len;
  logic              dir;
  logic [HOLD_W-1:0] hold;
  logic [DATA_W-1:0] pad_q;
  logic [DATA_W-1:0] rd_q;
  logic              rd_val_q;
  logic [DATA_W-1:0] cfg_word;

  logic cs;
  logic busy;
  logic accept;
  logic beat;
  logic tick;
  logic clr;
  logic cap;
  logic wr_load;
  logic last;
  logic expire;

  assign cs       = ~I_spi_cs_n;
  assign cfg_word = DATA_W'(I_req_ifcode) << 18;

  gbif_xfer_cnt #(
    .LEN_W  (LEN_W),
    .TIMEOUT(TIMEOUT)
  ) u_cnt (
    .clk   (I_clk),
    .rst   (I_rst),
    .clr   (clr),
    .beat  (beat),
    .tick  (tick),
    .len   (len),
    .last  (last),
    .expire(expire)
  );

  // Combinational outputs are forced quiet while reset is held.
  always_comb begin
    nxt           = state;
    accept        = 1'b0;
    beat          = 1'b0;
    tick          = 1'b0;
    clr           = 1'b0;
    cap           = 1'b0;
    wr_load       = 1'b0;
    busy          = 1'b0;
    O_req_rdy     = 1'b0;
    O_config_req  = 1'b0;
    O_switch_rdwr = 1'b0;
    O_pad_oe      = 1'b0;
    O_wr_rdy      = 1'b0;
    O_done        = 1'b0;
    O_err         = 1'b0;
    if (I_rst) begin
      O_req_rdy = 1'b1;
    end else begin
      busy          = (state != ST_IDLE);
      O_switch_rdwr = busy && dir;
      unique case (state)
        ST_IDLE: begin
          O_req_rdy = 1'b1;
          clr       = 1'b1;
          if (I_req_val) begin
            if (I_req_len == '0) begin
              O_err = 1'b1;
            end else begin
              accept = 1'b1;
              nxt    = ST_REQ;
            end
          end
        end
        ST_REQ: begin
          O_config_req = 1'b1;
          O_pad_oe     = 1'b1;
          if (!I_OE_req) begin
            O_pad_oe = 1'b0;
            O_err    = 1'b1;
            nxt      = ST_IDLE;
          end else if (hold == HOLD_LAST) begin
            nxt = dir ? ST_TURN : ST_WAIT_CS;
          end
        end
        ST_TURN: begin
          nxt = ST_WAIT_CS;
        end
        ST_WAIT_CS, ST_XFER: begin
          O_pad_oe = !dir;
          if (!dir && !I_OE_req) begin
            O_pad_oe = 1'b0;
            O_err    = 1'b1;
            nxt      = ST_IDLE;
          end else if (!cs) begin
            if (state == ST_XFER) begin
              O_err = 1'b1;
              nxt   = ST_IDLE;
            end else begin
              tick = 1'b1;
              if (expire) begin
                O_err = 1'b1;
                nxt   = ST_IDLE;
              end
            end
          end else if (dir || I_wr_val) begin
            beat     = 1'b1;
            cap      = dir;
            wr_load  = !dir;
            O_wr_rdy = !dir;
            nxt      = last ? ST_DONE : ST_XFER;
          end else begin
            O_err = 1'b1;
            nxt   = ST_IDLE;
          end
        end
        ST_DONE: begin
          O_done = 1'b1;
          nxt    = ST_IDLE;
        end
        default: nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state    <= ST_IDLE;
      len      <= '0;
      dir      <= 1'b0;
      hold     <= '0;
      pad_q    <= '0;
      rd_q     <= '0;
      rd_val_q <= 1'b0;
    end else begin
      state    <= nxt;
      rd_val_q <= cap;
      if (cap) rd_q <= I_pad_data;
      if (accept) begin
        len   <= I_req_len;
        dir   <= is_read(I_req_ifcode);
        hold  <= '0;
        pad_q <= cfg_word;
      end else if (state == ST_REQ) begin
        hold <= hold + 1'b1;
      end
      if (wr_load) pad_q <= I_wr_data;
    end
  end

  assign O_busy     = busy;
  assign O_pad_data = pad_q;
  assign O_rd_data  = rd_q;
  assign O_rd_val   = rd_val_q;

endmodule

// File: tb/tb_gbif_chip_requester.sv
// Bench for gbif_chip_requester: a host model drives the pad side
// and transfer outcomes are predicted from the protocol rules.
module tb_gbif_chip_requester;
  import gbif_pkg::*;

  localparam int DATA_W   = 128;
  localparam int LEN_W    = 20;
  localparam int CFG_HOLD = 3;
  localparam int TIMEOUT  = 1023;

  logic              I_clk;
  logic              I_rst;
  logic              I_req_val;
  logic              O_req_rdy;
  logic [3:0]        I_req_ifcode;
  logic [LEN_W-1:0]  I_req_len;
  logic              O_config_req;
  logic              O_switch_rdwr;
  logic              I_spi_cs_n;
  logic              I_OE_req;
  logic [DATA_W-1:0] I_pad_data;
  logic [DATA_W-1:0] O_pad_data;
  logic              O_pad_oe;
  logic [DATA_W-1:0] O_rd_data;
  logic              O_rd_val;
  logic [DATA_W-1:0] I_wr_data;
  logic              I_wr_val;
  logic              O_wr_rdy;
  logic              O_busy;
  logic              O_done;
  logic              O_err;

  int total;
  int bad;

  gbif_chip_requester #(
    .DATA_W  (DATA_W),
    .LEN_W   (LEN_W),
    .CFG_HOLD(CFG_HOLD),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .I_clk        (I_clk),
    .I_rst        (I_rst),
    .I_req_val    (I_req_val),
    .O_req_rdy    (O_req_rdy),
    .I_req_ifcode (I_req_ifcode),
    .I_req_len    (I_req_len),
    .O_config_req (O_config_req),
    .O_switch_rdwr(O_switch_rdwr),
    .I_spi_cs_n   (I_spi_cs_n),
    .I_OE_req     (I_OE_req),
    .I_pad_data   (I_pad_data),
    .O_pad_data   (O_pad_data),
    .O_pad_oe     (O_pad_oe),
    .O_rd_data    (O_rd_data),
    .O_rd_val     (O_rd_val),
    .I_wr_data    (I_wr_data),
    .I_wr_val     (I_wr_val),
    .O_wr_rdy     (O_wr_rdy),
    .O_busy       (O_busy),
    .O_done       (O_done),
    .O_err        (O_err)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  function automatic logic [DATA_W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request plus host-side activity; hb = beats the host offers,
  // drop_at = write beat with no data, rst_at = beat where reset hits.
  task automatic xact(input string tag, input logic [3:0] ifc,
                      input int len, input int hb, input int dly,
                      input int drop_at, input int rst_at);
    logic dir;
    logic [DATA_W-1:0] cw;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    int cfg_cyc, ifc_bad, sw_bad, oe_bad, nwr, ndone, nerr, err_cyc;
    int beat, wcnt, tail, eb, wbad, nbeat;
    bit seen, fell, cs_low, stop, rst_chk, prev_w, ok, fin;
    dir = !(ifc == IFCODE_FLGOFM || ifc == IFCODE_OFM);
    cw = '0;
    cw[21:18] = ifc;
    cfg_cyc = 0; ifc_bad = 0; sw_bad = 0; oe_bad = 0; nwr = 0;
    ndone = 0; nerr = 0; err_cyc = -1; beat = 0; wcnt = 0; tail = 0;
    seen = 0; fell = 0; stop = 0; rst_chk = 0; prev_w = 0; fin = 0;

    @(posedge I_clk); #1;
    I_req_val = 1'b1;
    I_req_ifcode = ifc;
    I_req_len = LEN_W'(len);
    #1;
    chk({tag, "/req_rdy"}, O_req_rdy, 1);

    for (int cyc = 1; cyc <= 3000 && !fin; cyc++) begin
      @(posedge I_clk); #1;
      I_req_val = 1'b0;
      cs_low = 1'b0;
      if (fell && !stop) begin
        if (wcnt < dly) wcnt++;
        else cs_low = (beat < hb);
      end
      I_spi_cs_n = !cs_low;
      I_pad_data = rnd();
      I_wr_data = rnd();
      I_wr_val = cs_low ? (beat != drop_at) : 1'($urandom);
      I_rst = cs_low && (beat == rst_at);
      #1;
      if (rst_chk) begin
        chk({tag, "/rst_busy"}, O_busy, 0);
        chk({tag, "/rst_oe"}, O_pad_oe, 0);
        rst_chk = 0;
      end
      if (O_config_req) begin
        cfg_cyc++;
        seen = 1;
        if (O_pad_data !== cw || O_pad_oe !== 1'b1) ifc_bad++;
      end else if (seen) begin
        fell = 1;
      end
      if (O_busy && O_switch_rdwr !== dir) sw_bad++;
      if (cs_low && !I_rst && beat < len && ndone == 0 && nerr == 0 &&
          (dir || I_wr_val) && O_pad_oe !== !dir) oe_bad++;
      if (prev_w) got_q.push_back(O_pad_data);
      prev_w = cs_low && !dir && I_wr_val;
      if (dir && O_rd_val) got_q.push_back(O_rd_data);
      if (O_wr_rdy) nwr++;
      if (cs_low) begin
        if (dir) exp_q.push_back(I_pad_data);
        else if (I_wr_val) exp_q.push_back(I_wr_data);
        beat++;
      end
      if (O_done) ndone++;
      if (O_err) begin
        nerr++;
        if (err_cyc < 0) err_cyc = cyc;
      end
      if (I_rst) begin
        stop = 1;
        rst_chk = 1;
      end
      if ((ndone > 0 || nerr > 0 || stop) && !cs_low && !rst_chk) tail++;
      if (tail >= 3) fin = 1;
    end
    I_rst = 1'b0;
    I_spi_cs_n = 1'b1;
    I_wr_val = 1'b0;

    chk({tag, "/finished"}, fin, 1);
    chk({tag, "/cfg_cycles"}, cfg_cyc, CFG_HOLD);
    chk({tag, "/cfg_word_bad"}, ifc_bad, 0);
    chk({tag, "/rdwr_bad"}, sw_bad, 0);
    chk({tag, "/oe_bad"}, oe_bad, 0);
    if (rst_at >= 0) begin
      chk({tag, "/done"}, ndone, 0);
      chk({tag, "/err"}, nerr, 0);
    end else begin
      if (hb == 0) begin
        eb = 0; ok = 0;
        chk({tag, "/tmo_cycle"}, err_cyc,
            dir ? CFG_HOLD + 1 + TIMEOUT : CFG_HOLD + TIMEOUT);
      end else if (!dir && drop_at >= 0 && drop_at < hb && drop_at < len) begin
        eb = drop_at; ok = 0;
      end else if (hb < len) begin
        eb = hb; ok = 0;
      end else begin
        eb = len; ok = 1;
      end
      nbeat = dir ? got_q.size() : nwr;
      wbad = 0;
      for (int i = 0; i < eb; i++)
        if (i >= got_q.size() || i >= exp_q.size() || got_q[i] !== exp_q[i])
          wbad++;
      chk({tag, "/done"}, ndone, ok ? 1 : 0);
      chk({tag, "/err"}, nerr, ok ? 0 : 1);
      chk({tag, "/beats"}, nbeat, eb);
      chk({tag, "/words_bad"}, wbad, 0);
    end
  endtask

  initial begin
    int l, hb, cfg_seen;
    logic [3:0] ifc;
    total = 0;
    bad = 0;
    I_rst = 1'b1;
    I_req_val = 1'b0;
    I_req_ifcode = '0;
    I_req_len = '0;
    I_spi_cs_n = 1'b1;
    I_OE_req = 1'b1;
    I_pad_data = '0;
    I_wr_data = '0;
    I_wr_val = 1'b0;
    repeat (3) @(posedge I_clk);
    #1;
    I_rst = 1'b0;
    #1;
    chk("rst/req_rdy", O_req_rdy, 1);
    chk("rst/busy", O_busy, 0);
    chk("rst/config_req", O_config_req, 0);
    chk("rst/pad_oe", O_pad_oe, 0);
    chk("rst/pad_data", O_pad_data, 0);
    chk("rst/rd_val", O_rd_val, 0);
    chk("rst/done_err", {O_done, O_err, O_wr_rdy, O_switch_rdwr}, 0);

    xact("cfg_rd", IFCODE_CFG, 64, 64, $urandom_range(0, 4), -1, -1);
    xact("ofm_wr", IFCODE_OFM, 64, 64, $urandom_range(0, 4), -1, -1);
    xact("act_tmo", IFCODE_ACT, 512, 0, 0, -1, -1);
    xact("wa_short", IFCODE_WEIADDR, 54, 22, 1, -1, -1);
    xact("fw_rst", IFCODE_FLGWEI, 512, 512, 0, -1, 10);
    l = $urandom_range(1, 40);
    xact("fa_after_rst", IFCODE_FLGACT, l, l, 0, -1, -1);

    @(posedge I_clk); #1;
    I_req_val = 1'b1;
    I_req_ifcode = IFCODE_CFG;
    I_req_len = '0;
    #1;
    chk("len0/err", O_err, 1);
    cfg_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge I_clk); #1;
      I_req_val = 1'b0;
      #1;
      if (O_config_req || O_busy) cfg_seen++;
    end
    chk("len0/no_cfg", cfg_seen, 0);

    xact("fo_drop", IFCODE_FLGOFM, 20, 20, 2, 5, -1);

    @(posedge I_clk); #1;
    I_req_val = 1'b1;
    I_req_ifcode = IFCODE_OFM;
    I_req_len = LEN_W'(4);
    #1;
    @(posedge I_clk); #1;
    I_req_val = 1'b0;
    #1;
    chk("conf/req_oe", {O_config_req, O_pad_oe}, 2'b11);
    @(posedge I_clk); #1;
    I_OE_req = 1'b0;
    #1;
    chk("conf/oe_err", {O_pad_oe, O_err}, 2'b01);
    @(posedge I_clk); #1;
    I_OE_req = 1'b1;
    #1;
    chk("conf/idle", {O_busy, O_req_rdy}, 2'b01);

    xact("len1_rd", IFCODE_WEI, 1, 1, 0, -1, -1);
    xact("len1_wr", IFCODE_OFM, 1, 1, 3, -1, -1);

    for (int t = 0; t < 6; t++) begin
      ifc = 4'($urandom_range(0, 7));
      l = $urandom_range(1, 30);
      hb = l + $urandom_range(0, 2);
      xact($sformatf("rand%0d", t), ifc, l, hb, $urandom_range(0, 5), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
